occupancy_decrementer: RTL and testbench

OCCUPANCY_DECREMENTER -- requirements
Module: occupancy_decrementer

---
 rtl/occupancy_decrementer_pkg.sv | 12 +
 rtl/occupancy_decrementer_full_subtractor.sv | 13 +
 rtl/occupancy_decrementer.sv | 120 ++++++++++++
 tb/tb_occupancy_decrementer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/occupancy_decrementer_pkg.sv
// Shared constants for the occupancy decrementer: FSM encoding and default width.
package occupancy_decrementer_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/occupancy_decrementer_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/occupancy_decrementer.sv
// Bit-serial occupancy decrementer: subtracts exit_cnt from occupancy one bit per cycle.
// Define UNDERFLOW_SAT_EN to clamp occupancy to 0 on underflow instead of wrapping.
// Handshake: exit_req is accepted only in IDLE with load=0; exit_ack pulses in the
// first SUB cycle, done pulses once when the result is committed; busy masks inputs.
module occupancy_decrementer
   import occupancy_decrementer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             exit_req,
   input  logic [WIDTH-1:0] exit_cnt,
   output logic             exit_ack,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] occupancy,
   output logic             borrow,
   output logic             empty,
   output state_e           dbg_state
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   occ_q, occ_d;
   logic               borrow_q, borrow_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               bin_q, bin_d;
   logic               fs_diff, fs_bout;

   // Single subtractor cell walked across the operand bits by idx_q.
   full_subtractor u_fs (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .bin  (bin_q),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   always_comb begin
      state_d  = state_q;
      occ_d    = occ_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      idx_d    = idx_q;
      bin_d    = bin_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               occ_d    = load_val;
               borrow_d = 1'b0;
            end else if (exit_req) begin
               a_d     = occ_q;
               b_d     = exit_cnt;
               res_d   = '0;
               idx_d   = '0;
               bin_d   = 1'b0;
               state_d = ST_SUB;
            end
         end
         ST_SUB: begin
            res_d[idx_q] = fs_diff;
            bin_d        = fs_bout;
            if (idx_q == LAST_IDX) begin
               borrow_d = fs_bout;
`ifdef UNDERFLOW_SAT_EN
               occ_d    = fs_bout ? '0 : res_d;
`else
               occ_d    = res_d;
`endif
               state_d  = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         occ_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         idx_q    <= '0;
         bin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         occ_q    <= occ_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         idx_q    <= idx_d;
         bin_q    <= bin_d;
      end
   end

   assign exit_ack  = (state_q == ST_SUB) && (idx_q == '0);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign occupancy = occ_q;
   assign borrow    = borrow_q;
   assign empty     = (occ_q == '0);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_occupancy_decrementer.sv
// Directed bench for occupancy_decrementer with an arithmetic reference model.
module tb_occupancy_decrementer;
  import occupancy_decrementer_pkg::*;

  localparam int W = 4;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         exit_req = 1'b0;
  logic [W-1:0] exit_cnt = '0;
  logic         exit_ack, busy, done, borrow, empty;
  logic [W-1:0] occupancy;
  state_e       dbg_state;

  int n_vec = 0;
  int n_fail = 0;
  int ack_seen = 0;
  int done_seen = 0;

  occupancy_decrementer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .exit_req  (exit_req),
    .exit_cnt  (exit_cnt),
    .exit_ack  (exit_ack),
    .busy      (busy),
    .done      (done),
    .occupancy (occupancy),
    .borrow    (borrow),
    .empty     (empty),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: phase 0 idle, 1..W subtracting, W+1 done
  int m_occ = 0;
  int m_borrow = 0;
  int m_phase = 0;
  int m_pend = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_occ = 0; m_borrow = 0; m_phase = 0; m_valid = 1'b1;
    end else if (m_phase == 0) begin
      if (load) begin
        m_occ = int'(load_val); m_borrow = 0;
      end else if (exit_req) begin
        m_pend = m_occ - int'(exit_cnt); m_phase = 1;
      end
    end else if (m_phase < W) begin
      m_phase++;
    end else if (m_phase == W) begin
      m_borrow = (m_pend < 0) ? 1 : 0;
`ifdef UNDERFLOW_SAT_EN
      m_occ = (m_pend < 0) ? 0 : m_pend;
`else
      m_occ = m_pend & ((1 << W) - 1);
`endif
      m_phase = W + 1;
    end else begin
      m_phase = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("occupancy", int'(occupancy), m_occ);
      check("borrow", int'(borrow), m_borrow);
      check("busy", int'(busy), int'(m_phase != 0));
      check("exit_ack", int'(exit_ack), int'(m_phase == 1));
      check("done", int'(done), int'(m_phase == W + 1));
      check("empty", int'(empty), int'(m_occ == 0));
      check("dbg_idle", int'(dbg_state == ST_IDLE), int'(m_phase == 0));
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    if (exit_ack) ack_seen++;
    if (done) done_seen++;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0; load_val = W'($urandom_range(0, 15));
  endtask

  task automatic run_exit(input logic [W-1:0] cnt, output int lat);
    ack_seen = 0; done_seen = 0;
    exit_req = 1'b1; exit_cnt = cnt;
    tick();
    exit_req = 1'b0; exit_cnt = W'($urandom_range(0, 15));
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    tick();
  endtask

  int lat;

  initial begin
    // reset for 2 cycles
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_occ", int'(occupancy), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_borrow", int'(borrow), 0);

    // basic exit: 9 - 3
    do_load(4'd9);
    run_exit(4'd3, lat);
    check("basic_lat", lat, LAT);
    check("basic_acks", ack_seen, 1);
    check("basic_occ", int'(occupancy), 6);
    check("basic_borrow", int'(borrow), 0);

    // underflow: 2 - 5
    do_load(4'd2);
    run_exit(4'd5, lat);
    check("uflow_lat", lat, LAT);
`ifdef UNDERFLOW_SAT_EN
    check("uflow_occ", int'(occupancy), 0);
`else
    check("uflow_occ", int'(occupancy), 13);
`endif
    check("uflow_borrow", int'(borrow), 1);

    // load clears borrow
    do_load(4'd10);
    check("load_clr_borrow", int'(borrow), 0);

    // collision: load and exit_req held during SUB
    do_load(4'd9);
    ack_seen = 0; done_seen = 0;
    exit_req = 1'b1; exit_cnt = 4'd4;
    tick();
    load = 1'b1; load_val = 4'd7;
    for (int i = 0; i < W - 1; i++) begin
      exit_cnt = W'($urandom_range(0, 15));
      tick();
    end
    exit_req = 1'b0; load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("coll_acks", ack_seen, 1);
    check("coll_dones", done_seen, 1);
    check("coll_occ", int'(occupancy), 5);

    // load and exit_req together in IDLE
    ack_seen = 0;
    load = 1'b1; load_val = 4'd7; exit_req = 1'b1; exit_cnt = 4'd2;
    tick();
    load = 1'b0; exit_req = 1'b0;
    tick();
    check("ld_win_occ", int'(occupancy), 7);
    check("ld_win_ack", ack_seen, 0);
    check("ld_win_busy", int'(busy), 0);

    // abort: rst in third SUB cycle of 8 - 1
    do_load(4'd8);
    done_seen = 0;
    exit_req = 1'b1; exit_cnt = 4'd1;
    tick();
    exit_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_occ", int'(occupancy), 0);
    check("abort_idle", int'(dbg_state == ST_IDLE), 1);
    check("abort_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_done", done_seen, 0);
    check("abort_occ_hold", int'(occupancy), 0);

    // boundary: 0 - 0
    run_exit(4'd0, lat);
    check("zero_lat", lat, LAT);
    check("zero_occ", int'(occupancy), 0);
    check("zero_borrow", int'(borrow), 0);
    check("zero_empty", int'(empty), 1);

    // boundary: 15 - 15
    do_load(4'd15);
    check("full_empty_pre", int'(empty), 0);
    run_exit(4'd15, lat);
    check("full_lat", lat, LAT);
    check("full_occ", int'(occupancy), 0);
    check("full_borrow", int'(borrow), 0);
    check("full_empty", int'(empty), 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
